// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// One shared hex decoder is time-sliced across digits 0..3. Every digit slot
// opens with an anode-off guard interval (BLANK) before the digit is driven
// (SHOW). New data is double-buffered and only reaches the display at a
// frame boundary, so one frame never mixes old and new digits.
module seg7_scan_ctrl #(
    parameter int unsigned CNT_DIGIT = 50000,
    parameter int unsigned CNT_BLANK = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        load,
    output logic        load_ack,
    output logic [0:6]  seg_out,
    output logic        dp_out,
    output logic [3:0]  an_out,
    output logic        frame_tick
);

    localparam int unsigned    CW        = (CNT_DIGIT > 1) ? $clog2(CNT_DIGIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CNT_DIGIT - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(CNT_BLANK);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_e;

    // Scan timing
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    state_e        state_q, state_d;
    logic          slot_wrap;
    logic          frame_end;

    // Pending (staging) register
    logic [15:0]   pend_val_q, pend_val_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_lz_q, pend_lz_d;
    logic          pend_flag_q, pend_flag_d;

    // Display register
    logic [15:0]   disp_val_q, disp_val_d;
    logic [3:0]    disp_dp_q, disp_dp_d;
    logic          disp_lz_q, disp_lz_d;
    logic          commit;

    // Registered outputs
    logic          ack_q, ack_d;
    logic          tick_q, tick_d;
    logic [0:6]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    // Output decode helpers
    logic [3:0]    nibble;
    logic          z1, z2, z3;
    logic          lz_hit;

    // Active-low hex glyphs, leftmost bit is segment a.
    function automatic logic [0:6] hex7(input logic [3:0] n);
        logic [0:6] g;
        unique case (n)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0001100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    // Prescaler, digit index and BLANK/SHOW phase for the next cycle.
    always_comb begin
        slot_wrap = (cnt_q == CNT_LAST);
        frame_end = slot_wrap && (digit_q == 2'd3);
        cnt_d     = slot_wrap ? '0 : cnt_q + CW'(1);
        digit_d   = slot_wrap ? digit_q + 2'd1 : digit_q;
        state_d   = state_q;
        unique case (state_q)
            BLANK: if (cnt_d == BLANK_END) state_d = SHOW;
            SHOW:  if (slot_wrap)          state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    // Double buffer: commit pending data at the frame boundary; a load on that
    // same edge is staged behind the commit rather than bypassing it.
    always_comb begin
        commit      = frame_end && pend_flag_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_lz_d   = pend_lz_q;
        pend_flag_d = pend_flag_q;
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        disp_lz_d   = disp_lz_q;
        if (commit) begin
            disp_val_d  = pend_val_q;
            disp_dp_d   = pend_dp_q;
            disp_lz_d   = pend_lz_q;
            pend_flag_d = 1'b0;
        end
        if (load) begin
            pend_val_d  = value_in;
            pend_dp_d   = dp_in;
            pend_lz_d   = blank_lz;
            pend_flag_d = 1'b1;
        end
        ack_d  = commit;
        tick_d = frame_end;
    end

    // Output decode from next-cycle state so outputs flip with the phase.
    always_comb begin
        nibble = disp_val_d[{digit_d, 2'b00} +: 4];
        z3     = (disp_val_d[15:12] == 4'h0);
        z2     = z3 && (disp_val_d[11:8] == 4'h0);
        z1     = z2 && (disp_val_d[7:4] == 4'h0);
        unique case (digit_d)
            2'd0:    lz_hit = 1'b0;
            2'd1:    lz_hit = z1;
            2'd2:    lz_hit = z2;
            default: lz_hit = z3;
        endcase
        lz_hit = lz_hit && disp_lz_d;

        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if (state_d == SHOW) begin
            an_d  = ~(4'b0001 << digit_d);
            seg_d = lz_hit ? 7'b1111111 : hex7(nibble);
            dp_d  = ~disp_dp_d[digit_d];
        end
    end

    // Scan FSM with its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            digit_q <= '0;
            state_q <= BLANK;
            an_q    <= '1;
            seg_q   <= '1;
            dp_q    <= 1'b1;
            ack_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            state_q <= state_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            ack_q   <= ack_d;
            tick_q  <= tick_d;
        end
    end

    // Pending and display data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            pend_lz_q   <= 1'b0;
            pend_flag_q <= 1'b0;
            disp_val_q  <= '0;
            disp_dp_q   <= '0;
            disp_lz_q   <= 1'b0;
        end else begin
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            pend_lz_q   <= pend_lz_d;
            pend_flag_q <= pend_flag_d;
            disp_val_q  <= disp_val_d;
            disp_dp_q   <= disp_dp_d;
            disp_lz_q   <= disp_lz_d;
        end
    end

    assign load_ack   = ack_q;
    assign frame_tick = tick_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: every cycle is compared against a frame-position
// model (edges since reset, modulo the frame length) holding the double buffer.
module tb_seg7_scan_ctrl;

    localparam int CD = 8;
    localparam int CB = 2;
    localparam int FR = 4 * CD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic        load = 1'b0;
    logic        load_ack;
    logic [0:6]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_tick;

    seg7_scan_ctrl #(.CNT_DIGIT(CD), .CNT_BLANK(CB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .load       (load),
        .load_ack   (load_ack),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    int unsigned k;
    logic        m_pend;
    logic [15:0] m_pval, m_dval;
    logic [3:0]  m_pdp, m_ddp;
    logic        m_plz, m_dlz;
    logic        m_ack;

    // Glyphs written a..g left to right, active low.
    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; m_pend = 0; m_ack = 0;
        m_pval = '0; m_pdp = '0; m_plz = 0;
        m_dval = '0; m_ddp = '0; m_dlz = 0;
    endtask

    task automatic check_outputs();
        int unsigned pos, dig, off;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [15:0] upper;
        pos = k % FR;
        dig = pos / CD;
        off = pos % CD;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (off >= CB) begin
            e_an  = ~(4'b0001 << dig);
            upper = m_dval >> (4 * dig);
            e_seg = (m_dlz && dig != 0 && upper == 0) ? 7'h7F : glyph[(m_dval >> (4 * dig)) & 16'hF];
            e_dp  = ~m_ddp[dig];
        end
        check_eq("an_out", 16'(an_out), 16'(e_an));
        check_eq("seg_out", 16'(seg_out), 16'(e_seg));
        check_eq("dp_out", 16'(dp_out), 16'(e_dp));
        check_eq("load_ack", 16'(load_ack), 16'(m_ack));
        check_eq("frame_tick", 16'(frame_tick), 16'(pos == 0 && k > 0));
    endtask

    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic bl);
        load = ld; value_in = v; dp_in = d; blank_lz = bl;
        @(posedge clk);
        k++;
        m_ack = 0;
        if (k % FR == 0 && m_pend) begin
            m_dval = m_pval; m_ddp = m_pdp; m_dlz = m_plz;
            m_pend = 0; m_ack = 1;
        end
        if (ld) begin
            m_pval = v; m_pdp = d; m_plz = bl; m_pend = 1;
        end
        #1;
        load = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();
        idle(40);

        step(1'b1, 16'h12AF, 4'b0000, 1'b0);
        idle(70);

        step(1'b1, 16'h0005, 4'b0000, 1'b1);
        idle(70);
        step(1'b1, 16'h0000, 4'b0000, 1'b1);
        idle(70);

        while (k % FR != 1) idle(1);
        step(1'b1, 16'h1111, 4'b0000, 1'b0);
        idle(2);
        step(1'b1, 16'h2222, 4'b0000, 1'b0);
        idle(70);

        while (k % FR != 5) idle(1);
        step(1'b1, 16'hBEEF, 4'b1000, 1'b0);
        while ((k + 1) % FR != 0) idle(1);
        step(1'b1, 16'h3C4D, 4'b0001, 1'b0);
        idle(70);

        step(1'b1, 16'h8421, 4'b0101, 1'b0);
        idle(70);

        while (k % FR != 1) idle(1);
        step(1'b1, 16'h7777, 4'hF, 1'b1);
        while (k % FR != 19) idle(1);
        do_reset();
        idle(70);

        repeat (30) begin
            step(1'b1, 16'($urandom), 4'($urandom), 1'($urandom));
            idle(int'($urandom_range(0, 45)));
        end
        repeat (6) begin
            step(1'b1, 16'(1) << (4 * $urandom_range(0, 3)), 4'($urandom), 1'b1);
            idle(int'($urandom_range(20, 45)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
